rs_chien_forney_par: RTL and testbench

- Parametrised Chien search and Forney evaluator for the Reed-Solomon decoder over GF(2^M).
- Sits after the key-equation solver and before the correction adder.
- Takes error-locator Lambda and evaluator Omega as parallel vectors. Supports shortened codes via a skip phase.
- Streams one (position, root flag, magnitude) beat per codeword symbol under valid/ready backpressure, then reports root count and decode failure.

---
 rtl/rs_gf_pkg.sv | 66 ++++++
 rtl/rs_chien_forney_par_if.sv | 36 +++
 rtl/rs_forney_div.sv | 18 +
 rtl/rs_chien_forney_par.sv | 203 ++++++++++++++++++++
 tb/tb_rs_chien_forney_par.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_gf_pkg.sv
// GF(2^M) helpers and shared types for the Reed-Solomon Chien/Forney block.
// Field operations work on a 16-bit container. The active field width m and
// the reduction polynomial poly (which includes the x^m term) are passed in,
// so a single package serves every parametrisation of the block.
// Contents:
//   Q            - field size for the default M=8
//   gf_mul       - polynomial multiply with reduction by poly
//   gf_pow       - a^e by square-and-multiply
//   gf_alpha_pow - alpha^k, where alpha = x
//   gf_const_mul - x * alpha^k
//   gf_inv       - a^(2^m-2); gf_inv(0) = 0
//   state_t      - controller states
package rs_gf_pkg;

   localparam int GF_M = 8;
   localparam int Q    = 32'sd1 << GF_M;
   localparam int GF_W = 16;

   typedef logic [GF_W-1:0] gf_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SKIP   = 3'd2,
      SEARCH = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Shift-and-add multiply, MSB of b first, reducing as each bit m appears
   function automatic gf_t gf_mul(input gf_t a, input gf_t b, input int m, input gf_t poly);
      gf_t r;
      r = {GF_W{1'b0}};
      for (int i = GF_W - 1; i >= 0; i--) begin
         if (i < m) begin
            r = {r[GF_W-2:0], 1'b0};
            if (r[m[3:0]] == 1'b1) r = r ^ poly;
            if (b[i] == 1'b1) r = r ^ a;
         end
      end
      return r;
   endfunction

   function automatic gf_t gf_pow(input gf_t a, input gf_t e, input int m, input gf_t poly);
      gf_t r;
      r = gf_t'(1'b1);
      for (int i = GF_W - 1; i >= 0; i--) begin
         r = gf_mul(r, r, m, poly);
         if (e[i] == 1'b1) r = gf_mul(r, a, m, poly);
      end
      return r;
   endfunction

   function automatic gf_t gf_alpha_pow(input gf_t k, input int m, input gf_t poly);
      return gf_pow(gf_t'(2'd2), k, m, poly);
   endfunction

   function automatic gf_t gf_const_mul(input gf_t x, input gf_t k, input int m, input gf_t poly);
      return gf_mul(x, gf_alpha_pow(k, m, poly), m, poly);
   endfunction

   // The exponent 2^m-2 sends 0 to 0, which the Forney path relies on
   function automatic gf_t gf_inv(input gf_t a, input int m, input gf_t poly);
      return gf_pow(a, gf_t'((32'd1 << m) - 32'd2), m, poly);
   endfunction

endpackage

// File: rtl/rs_chien_forney_par_if.sv
// Bus between the key-equation side and the Chien/Forney block.
// master: the key-equation side and the downstream correction stage.
//         It drives start, n_len, lambda_in, omega_in and out_ready.
// slave:  rs_chien_forney_par. It drives idle, the out_* beat signals,
//         done, err_count and fail.
interface rs_chien_forney_par_if
   import rs_gf_pkg::*;
#(
   parameter int M = 8,
   parameter int T = 8
);
   logic                 start;
   logic                 idle;
   logic [M-1:0]         n_len;
   logic [(T+1)*M-1:0]   lambda_in;
   logic [T*M-1:0]       omega_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [M-1:0]         out_pos;
   logic                 out_err;
   logic [M-1:0]         out_mag;
   logic                 out_last;
   logic                 done;
   logic [M-1:0]         err_count;
   logic                 fail;

   modport master (
      output start, n_len, lambda_in, omega_in, out_ready,
      input  idle, out_valid, out_pos, out_err, out_mag, out_last, done, err_count, fail
   );

   modport slave (
      input  start, n_len, lambda_in, omega_in, out_ready,
      output idle, out_valid, out_pos, out_err, out_mag, out_last, done, err_count, fail
   );
endinterface

// File: rtl/rs_forney_div.sv
// Forney magnitude: mag = num * inv(odd). When odd = 0 the result is 0.
// The block is purely combinational and is kept separate so a pipeline stage
// can be added here later without touching the search controller.
// Ports: num (Omega at x), odd (odd half of Lambda at x), mag (result).
module rs_forney_div
   import rs_gf_pkg::*;
#(
   parameter int         M         = 8,
   parameter logic [M:0] PRIM_POLY = 9'h187
) (
   input  logic [M-1:0] num,
   input  logic [M-1:0] odd,
   output logic [M-1:0] mag
);
   localparam gf_t POLY = gf_t'(PRIM_POLY);

   assign mag = M'(gf_mul(gf_t'(num), gf_inv(gf_t'(odd), M, POLY), M, POLY));
endmodule

// File: rtl/rs_chien_forney_par.sv
// Parallel Chien search and Forney evaluator for RS over GF(2^M).
// Ports:
//   clk, clrn - clock; asynchronous active-low reset
//   bus       - slave side of the rs_chien_forney_par_if bus:
//               start/idle load handshake, n_len, lambda_in and omega_in in;
//               out_* beat stream with valid/ready;
//               done pulse with err_count and fail.
// The coefficient registers walk x = alpha^k. A skip phase first advances
// them to alpha^(2^M-N), which is position N-1 of a shortened code. After
// that, each emitted beat advances one position, down to position 0.
module rs_chien_forney_par
   import rs_gf_pkg::*;
#(
   parameter int         M         = 8,
   parameter int         T         = 8,
   parameter logic [M:0] PRIM_POLY = 9'h187
) (
   input logic                  clk,
   input logic                  clrn,
   rs_chien_forney_par_if.slave bus
);
   localparam int  QF   = 32'sd1 << M;
   localparam gf_t POLY = gf_t'(PRIM_POLY);

   state_t       state_r, state_s;
   logic [M-1:0] l_r [0:T];
   logic [M-1:0] o_r [0:T-1];
   logic [M-1:0] l_mul_s [0:T];
   logic [M-1:0] o_mul_s [0:T-1];
   logic [M-1:0] n_r, deg_r, deg_s, beats_r, err_count_r, cnt_nxt_s;
   logic [M:0]   skip_len_s, skip_cnt_r;
   logic [M-1:0] even_s, odd_s, num_s, mag_s, out_pos_r, out_mag_r;
   logic         lam0z_r, step_s, load_beat_s, acc_s, root_s, bad_s, bad_nxt_s;
   logic         out_valid_r, out_err_r, out_last_r, out_bad_r, done_r, idle_r, fail_r, bad_seen_r;

   // Each coefficient has a constant multiplier by alpha^j
   for (genvar j = 0; j <= T; j++) begin : g_lmul
      assign l_mul_s[j] = M'(gf_const_mul(gf_t'(l_r[j]), gf_t'(j), M, POLY));
   end
   for (genvar j = 0; j < T; j++) begin : g_omul
      assign o_mul_s[j] = M'(gf_const_mul(gf_t'(o_r[j]), gf_t'(j), M, POLY));
   end

   // Evaluate Lambda as even/odd halves and Omega at the current point
   always_comb begin
      even_s = {M{1'b0}};
      odd_s  = {M{1'b0}};
      num_s  = {M{1'b0}};
      for (int j = 0; j <= T; j++) begin
         if (j[0] == 1'b0) even_s = even_s ^ l_r[j];
         else              odd_s  = odd_s ^ l_r[j];
      end
      for (int j = 0; j < T; j++) num_s = num_s ^ o_r[j];
      root_s = (even_s == odd_s);
      bad_s  = root_s && (odd_s == {M{1'b0}});
   end

   rs_forney_div #(.M(M), .PRIM_POLY(PRIM_POLY)) u_div (.num(num_s), .odd(odd_s), .mag(mag_s));

   // Degree of the incoming Lambda: index of the highest non-zero coefficient
   always_comb begin
      deg_s = {M{1'b0}};
      for (int j = 0; j <= T; j++) begin
         if (bus.lambda_in[j*M +: M] != {M{1'b0}}) deg_s = M'(j);
         else                                      deg_s = deg_s;
      end
   end

   // Next-state logic and step/beat strobes
   always_comb begin
      state_s     = state_r;
      load_beat_s = 1'b0;
      step_s      = 1'b0;
      acc_s       = out_valid_r & bus.out_ready;
      skip_len_s  = (M+1)'(QF) - {1'b0, n_r};
      case (state_r)
         IDLE: begin
            if (bus.start) state_s = LOAD;
            else           state_s = IDLE;
         end
         LOAD: begin
            if (skip_len_s != {(M+1){1'b0}}) state_s = SKIP;
            else                             state_s = SEARCH;
         end
         SKIP: begin
            step_s = 1'b1;
            if (skip_cnt_r == skip_len_s - (M+1)'(1)) state_s = SEARCH;
            else                                      state_s = SKIP;
         end
         SEARCH: begin
            // Refill the output register only when it is empty or being drained
            if ((!out_valid_r || bus.out_ready) && (beats_r < n_r)) begin
               load_beat_s = 1'b1;
               step_s      = 1'b1;
            end else begin
               load_beat_s = 1'b0;
               step_s      = 1'b0;
            end
            if (acc_s && out_last_r) state_s = DONE;
            else                     state_s = SEARCH;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Root count (saturating) and odd==0 tracking from accepted beats
   always_comb begin
      cnt_nxt_s = err_count_r;
      bad_nxt_s = bad_seen_r;
      if (acc_s) begin
         if (out_err_r && (err_count_r != {M{1'b1}})) cnt_nxt_s = err_count_r + M'(1);
         else                                        cnt_nxt_s = err_count_r;
         bad_nxt_s = bad_seen_r | out_bad_r;
      end else begin
         cnt_nxt_s = err_count_r;
         bad_nxt_s = bad_seen_r;
      end
   end

   // State register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Coefficient registers: load on start, multiply by alpha^j on each step
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int j = 0; j <= T; j++) l_r[j] <= {M{1'b0}};
         for (int j = 0; j < T; j++)  o_r[j] <= {M{1'b0}};
      end else if (state_r == IDLE && bus.start) begin
         for (int j = 0; j <= T; j++) l_r[j] <= bus.lambda_in[j*M +: M];
         for (int j = 0; j < T; j++)  o_r[j] <= bus.omega_in[j*M +: M];
      end else if (step_s) begin
         for (int j = 0; j <= T; j++) l_r[j] <= l_mul_s[j];
         for (int j = 0; j < T; j++)  o_r[j] <= o_mul_s[j];
      end
   end

   // Control counters, output beat register and completion status
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         n_r         <= {M{1'b0}};
         deg_r       <= {M{1'b0}};
         lam0z_r     <= 1'b0;
         skip_cnt_r  <= {(M+1){1'b0}};
         beats_r     <= {M{1'b0}};
         out_valid_r <= 1'b0;
         out_pos_r   <= {M{1'b0}};
         out_err_r   <= 1'b0;
         out_mag_r   <= {M{1'b0}};
         out_last_r  <= 1'b0;
         out_bad_r   <= 1'b0;
         err_count_r <= {M{1'b0}};
         bad_seen_r  <= 1'b0;
         fail_r      <= 1'b0;
         done_r      <= 1'b0;
         idle_r      <= 1'b1;
      end else begin
         idle_r      <= (state_s == IDLE);
         done_r      <= (state_s == DONE);
         err_count_r <= cnt_nxt_s;
         bad_seen_r  <= bad_nxt_s;
         if (state_r == IDLE && bus.start) begin
            n_r         <= bus.n_len;
            deg_r       <= deg_s;
            lam0z_r     <= (bus.lambda_in[M-1:0] == {M{1'b0}});
            skip_cnt_r  <= {(M+1){1'b0}};
            beats_r     <= {M{1'b0}};
            out_valid_r <= 1'b0;
            err_count_r <= {M{1'b0}};
            bad_seen_r  <= 1'b0;
            fail_r      <= 1'b0;
         end else begin
            if (state_r == SKIP) skip_cnt_r <= skip_cnt_r + (M+1)'(1);
            if (load_beat_s) begin
               out_valid_r <= 1'b1;
               out_pos_r   <= n_r - M'(1) - beats_r;
               out_err_r   <= root_s;
               out_mag_r   <= root_s ? mag_s : {M{1'b0}};
               out_last_r  <= (beats_r == n_r - M'(1));
               out_bad_r   <= bad_s;
               beats_r     <= beats_r + M'(1);
            end else if (acc_s) begin
               out_valid_r <= 1'b0;
            end
            if (state_r == SEARCH && state_s == DONE)
               fail_r <= lam0z_r | (cnt_nxt_s != deg_r) | bad_nxt_s;
         end
      end
   end

   assign bus.idle      = idle_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_pos   = out_pos_r;
   assign bus.out_err   = out_err_r;
   assign bus.out_mag   = out_mag_r;
   assign bus.out_last  = out_last_r;
   assign bus.done      = done_r;
   assign bus.err_count = err_count_r;
   assign bus.fail      = fail_r;
endmodule

// File: tb/tb_rs_chien_forney_par.sv
`timescale 1ns/1ps
module tb_rs_chien_forney_par;
   localparam int M = 8;
   localparam int T = 8;

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   rs_chien_forney_par_if #(.M(M), .T(T)) bus ();
   rs_chien_forney_par #(.M(M), .T(T), .PRIM_POLY(9'h187)) dut (.clk(clk), .clrn(clrn), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Log/antilog tables built by repeated multiplication by alpha
   int gexp [0:254];
   int glog [0:255];
   int cw_lam [0:T];
   int cw_om  [0:T-1];

   typedef struct {int pos; int err; int mag; int last;} beat_t;
   beat_t exp_q[$];
   int exp_cnt;
   int exp_fail;

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction

   function automatic int ginv(input int a);
      if (a == 0) return 0;
      return gexp[(255 - glog[a]) % 255];
   endfunction

   function automatic int gpow(input int a, input int e);
      if (a == 0) return (e == 0) ? 1 : 0;
      return gexp[(glog[a] * e) % 255];
   endfunction

   task automatic build_tables();
      int e;
      e = 1;
      for (int i = 0; i < 256; i++) glog[i] = 0;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = e;
         glog[e] = i;
         e = e << 1;
         if ((e & 256) != 0) e = e ^ 'h187;
      end
   endtask

   // Reference: position p is located at x = alpha^(-p). A root is where
   // Lambda(x) = 0, and the magnitude is Omega(x) / (x * Lambda'(x)).
   task automatic build_model(input int n);
      int roots, bad, deg;
      roots = 0; bad = 0; deg = 0;
      exp_q.delete();
      for (int j = 0; j <= T; j++) if (cw_lam[j] != 0) deg = j;
      for (int p = n - 1; p >= 0; p--) begin
         int x, lv, dv, nv;
         beat_t b;
         x = gexp[(255 - p) % 255];
         lv = 0; dv = 0; nv = 0;
         for (int j = 0; j <= T; j++) begin
            lv = lv ^ gmul(cw_lam[j], gpow(x, j));
            if (j % 2 == 1) dv = dv ^ gmul(cw_lam[j], gpow(x, j));
         end
         for (int j = 0; j < T; j++) nv = nv ^ gmul(cw_om[j], gpow(x, j));
         b.pos  = p;
         b.err  = (lv == 0) ? 1 : 0;
         b.mag  = (lv == 0) ? gmul(nv, ginv(dv)) : 0;
         b.last = (p == 0) ? 1 : 0;
         if (lv == 0) begin
            roots++;
            if (dv == 0) bad = 1;
         end
         exp_q.push_back(b);
      end
      exp_cnt  = (roots > 255) ? 255 : roots;
      exp_fail = ((cw_lam[0] == 0) || (exp_cnt != deg) || (bad != 0)) ? 1 : 0;
   endtask

   task automatic set_coeffs(input int l0, input int l1, input int l2, input int o0);
      for (int j = 0; j <= T; j++) cw_lam[j] = 0;
      for (int j = 0; j < T; j++) cw_om[j] = 0;
      cw_lam[0] = l0; cw_lam[1] = l1; cw_lam[2] = l2; cw_om[0] = o0;
   endtask

   task automatic drive_start(input int n);
      @(negedge clk);
      bus.n_len = n[7:0];
      for (int j = 0; j <= T; j++) bus.lambda_in[j*8 +: 8] = cw_lam[j][7:0];
      for (int j = 0; j < T; j++)  bus.omega_in[j*8 +: 8]  = cw_om[j][7:0];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // rdy_mode: 0 always ready, 1 random ready, 2 three-cycle stall at pos 250
   task automatic run_cw(input string name, input int n, input int rdy_mode, input int exp_first);
      int c, got, first_c, last_acc_c, hold, done_seen;
      build_model(n);
      drive_start(n);
      c = 0; got = 0; first_c = -1; last_acc_c = -1; hold = 0; done_seen = 0;
      while (done_seen == 0 && c < 3000) begin
         if (bus.done === 1'b1) begin
            done_seen = 1;
         end else begin
            if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 2 && bus.out_valid === 1'b1 && bus.out_pos === 8'd250 && hold < 3) begin
               bus.out_ready = 1'b0;
               hold++;
            end else bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1) begin
               if (first_c < 0) first_c = c;
               checks++;
               if (got >= exp_q.size()) begin
                  errors++;
                  $display("FAIL %s extra_beat got pos %0d beyond %0d expected beats", name, bus.out_pos, n);
               end else if ({bus.out_pos, bus.out_err, bus.out_mag, bus.out_last} !==
                            {8'(exp_q[got].pos), 1'(exp_q[got].err), 8'(exp_q[got].mag), 1'(exp_q[got].last)}) begin
                  errors++;
                  $display("FAIL %s beat%0d got pos=%0d err=%0b mag=%h last=%0b expected pos=%0d err=%0d mag=%h last=%0d",
                           name, got, bus.out_pos, bus.out_err, bus.out_mag, bus.out_last,
                           exp_q[got].pos, exp_q[got].err, exp_q[got].mag, exp_q[got].last);
               end
               if (bus.out_ready === 1'b1) begin
                  got++;
                  last_acc_c = c;
               end
            end
            @(negedge clk);
            c++;
         end
      end
      bus.out_ready = 1'b1;
      checks++;
      if (done_seen == 0) begin
         errors++;
         $display("FAIL %s done_timeout got no done within %0d cycles, expected a done pulse", name, c);
      end else begin
         checks++;
         if (c != last_acc_c + 1) begin
            errors++;
            $display("FAIL %s done_cycle got %0d expected %0d", name, c, last_acc_c + 1);
         end
         checks++;
         if (bus.err_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL %s err_count got %0d expected %0d", name, bus.err_count, exp_cnt);
         end
         checks++;
         if (bus.fail !== 1'(exp_fail)) begin
            errors++;
            $display("FAIL %s fail_flag got %0b expected %0d", name, bus.fail, exp_fail);
         end
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL %s beat_count got %0d expected %0d", name, got, n);
      end
      if (exp_first >= 0) begin
         checks++;
         if (first_c != exp_first) begin
            errors++;
            $display("FAIL %s first_valid got cycle %0d expected %0d", name, first_c, exp_first);
         end
      end
      if (rdy_mode == 2) begin
         checks++;
         if (hold != 3) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d expected 3", name, hold);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.idle} !== 2'b01) begin
         errors++;
         $display("FAIL %s after_done got done=%0b idle=%0b expected done=0 idle=1", name, bus.done, bus.idle);
      end
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      bus.start = 1'b1;
      bus.n_len = 8'd10;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.idle, bus.out_valid, bus.err_count, bus.fail, bus.done, bus.out_pos, bus.out_mag} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values got idle=%0b valid=%0b cnt=%0d fail=%0b done=%0b pos=%0d mag=%h expected 1 0 0 0 0 0 00",
                  bus.idle, bus.out_valid, bus.err_count, bus.fail, bus.done, bus.out_pos, bus.out_mag);
      end
      bus.start = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.idle, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_start_ignored got idle=%0b valid=%0b expected idle=1 valid=0", bus.idle, bus.out_valid);
      end
   endtask

   task automatic test_single_err();
      set_coeffs(1, 1, 0, 'h5A);
      run_cw("n255_single", 255, 0, 3);
   endtask

   task automatic test_shortened();
      set_coeffs(1, 1, 0, 'h5A);
      run_cw("n10_short", 10, 0, 248);
   endtask

   task automatic test_no_err();
      set_coeffs(1, 0, 0, 'h5A);
      run_cw("n255_clean", 255, 0, -1);
   endtask

   task automatic test_fail_cases();
      set_coeffs(1, 0, 1, 'h5A);
      run_cw("double_root", 30, 0, -1);
      set_coeffs(0, 1, 0, 'h33);
      run_cw("lambda0_zero", 30, 0, -1);
   endtask

   task automatic test_backpressure();
      set_coeffs(1, 1, 0, 'h5A);
      run_cw("backpressure", 255, 2, 3);
   endtask

   task automatic test_reset_mid();
      int done_hit;
      set_coeffs(1, 1, 0, 'h5A);
      drive_start(255);
      repeat (30) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_busy got valid=%0b expected 1", bus.out_valid);
      end
      clrn = 1'b0;
      #1;
      checks++;
      if ({bus.idle, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL midreset_abort got idle=%0b valid=%0b expected idle=1 valid=0", bus.idle, bus.out_valid);
      end
      @(negedge clk);
      clrn = 1'b1;
      done_hit = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_hit = 1;
      end
      checks++;
      if (done_hit != 0 || bus.idle !== 1'b1) begin
         errors++;
         $display("FAIL midreset_no_done got done_seen=%0d idle=%0b expected done_seen=0 idle=1", done_hit, bus.idle);
      end
   endtask

   // Random codewords: Lambda is built from distinct error locations
   task automatic test_random();
      for (int k = 0; k < 5; k++) begin
         int n, e, p;
         bit used [0:254];
         n = $urandom_range(20, 255);
         e = $urandom_range(0, T);
         for (int i = 0; i < 255; i++) used[i] = 1'b0;
         for (int j = 0; j <= T; j++) cw_lam[j] = 0;
         cw_lam[0] = 1;
         for (int i = 0; i < e; i++) begin
            p = $urandom_range(0, n - 1);
            while (used[p]) p = $urandom_range(0, n - 1);
            used[p] = 1'b1;
            for (int j = T; j >= 1; j--) cw_lam[j] = cw_lam[j] ^ gmul(gexp[p % 255], cw_lam[j-1]);
         end
         for (int j = 0; j < T; j++) cw_om[j] = $urandom_range(0, 255);
         run_cw($sformatf("random%0d", k), n, 1, -1);
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.n_len     = 8'd0;
      bus.lambda_in = {((T+1)*M){1'b0}};
      bus.omega_in  = {(T*M){1'b0}};
      bus.out_ready = 1'b1;
      build_tables();
      test_reset();
      test_single_err();
      test_shortened();
      test_no_err();
      test_fail_cases();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
